aes_key_sched: RTL and testbench

- Parametrised iterative AES key schedule for AES-128, AES-192 and AES-256, following FIPS-197.
- Expands a cipher key one 32-bit word per clock into an internal round-key store of up to 60 words.
- The store has a random-access read port, so the encryption datapath reads rounds 0..Nr forward and the decryption datapath reads them in reverse.
- Sits between the key-load register interface and the AES round datapath. It replaces per-round on-the-fly expansion, which only supports forward order.

---
 rtl/aes_key_sched.sv | 118 +++++++++++
 tb/tb_aes_key_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative FIPS-197 key expansion (AES-128/192/256) into a random-access round-key store.
module aes_key_sched #(
  parameter int MAX_WORDS = 60,
  parameter int SUPPORT_256 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rk_out
);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
  state_t state;
  logic [1:0] mode;
  logic [255:0] key;
  logic [31:0] w [MAX_WORDS];
  logic [5:0] i, nk, last, rbase;
  logic [2:0] j;
  logic [7:0] rcon;
  logic [3:0] mode_nr;
  logic len_ok;
  logic [31:0] prev, rot, sub, temp, next_word;
  assign nk = mode == 2'd0 ? 6'd4 : mode == 2'd1 ? 6'd6 : 6'd8;
  assign last = mode == 2'd0 ? 6'd43 : mode == 2'd1 ? 6'd51 : 6'd59;
  assign mode_nr = mode == 2'd0 ? 4'd10 : mode == 2'd1 ? 4'd12 : 4'd14;
  assign len_ok = key_len != 2'b11 && (key_len != 2'b10 || SUPPORT_256 != 0);
  assign prev = w[i - 6'd1];
  assign rot = j == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
  sub_word u_sub (.a(rot), .y(sub));
  assign temp = j == 3'd0 ? sub ^ {rcon, 24'h0} : (nk == 6'd8 && j == 3'd4) ? sub : prev;
  assign next_word = w[i - nk] ^ temp;
  assign rbase = {rd_idx, 2'b00};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode <= 2'd0;
      key <= '0;
      i <= 6'd0;
      j <= 3'd0;
      rcon <= 8'h01;
      busy <= 1'b0;
      done <= 1'b0;
      key_valid <= 1'b0;
      err <= 1'b0;
      nr <= 4'd0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE:
          if (start && len_ok) begin
            state <= LOAD;
            mode <= key_len;
            key <= cipher_key;
            busy <= 1'b1;
            key_valid <= 1'b0;
            nr <= 4'd0;
          end else if (start) err <= 1'b1;
        LOAD: begin
          i <= nk;
          j <= 3'd0;
          rcon <= 8'h01;
          state <= EXPAND;
        end
        EXPAND: begin
          i <= i + 6'd1;
          j <= {3'd0, j} == nk - 6'd1 ? 3'd0 : j + 3'd1;
          if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (i == last) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            key_valid <= 1'b1;
            nr <= mode_nr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Store has no reset: its contents only matter once key_valid is set.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int k = 0; k < 8; k++)
        if (k < int'(nk)) w[k] <= key[255-32*k -: 32];
    end else if (state == EXPAND) w[i] <= next_word;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rk_out <= '0;
    else rk_out <= key_valid && rd_idx <= nr ? {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]} : '0;
  end
endmodule

module sub_word (
  input  logic [31:0] a,
  output logic [31:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Entry x sits at bit 2047-8x, which is simply {~x, 3'b111}.
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign y[8*b +: 8] = SBOX[{~a[8*b +: 8], 3'b111} -: 8];
  end
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: scoreboard bench for aes_key_sched using FIPS-197 schedules.
module tb_aes_key_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] key_len = 2'd0;
  logic [255:0] cipher_key = '0;
  logic busy, done, key_valid, err;
  logic [3:0] nr;
  logic [3:0] rd_idx = 4'd0;
  logic [127:0] rk_out;
  int n_checks = 0, n_errors = 0, cyc = 0, t0 = 0, lat;
  typedef struct { logic [127:0] val; int idx; } rd_t;
  rd_t sb[$];
  rd_t e;
  logic [127:0] r128 [11];
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_55aa55aa};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched dut (.clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .cipher_key(cipher_key),
    .busy(busy), .done(done), .key_valid(key_valid), .err(err), .nr(nr), .rd_idx(rd_idx), .rk_out(rk_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read results appear one cycle after rd_idx is driven.
  always @(posedge clk)
    if (sb.size() > 0) begin
      #1;
      e = sb.pop_front();
      check($sformatf("rk[%0d]", e.idx), rk_out, e.val);
    end

  task automatic issue(input int idx, input logic [127:0] exp);
    @(negedge clk);
    rd_idx = idx[3:0];
    sb.push_back('{val: exp, idx: idx});
  endtask

  task automatic kick(input logic [1:0] len, input logic [255:0] key);
    @(negedge clk);
    start = 1'b1;
    key_len = len;
    cipher_key = key;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        l = cyc - t0;
        return;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    r128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    r128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    r128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    r128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    r128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    r128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    r128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    r128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    r128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    r128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    r128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", key_valid, 0);
    check("rst_err", err, 0);
    check("rst_nr", nr, 0);
    check("rst_rk", rk_out, 0);

    kick(2'b00, K128);
    check("busy_on", busy, 1);
    check("valid_off", key_valid, 0);
    wait_done(lat);
    check("lat128", lat, 42);
    check("nr128", nr, 10);
    check("valid128", key_valid, 1);
    check("busy_off", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    issue(1, r128[1]);
    issue(10, r128[10]);
    issue(0, r128[0]);
    for (int r = 10; r >= 0; r--) issue(r, r128[r]);
    for (int r = 11; r < 16; r++) issue(r, 0);

    kick(2'b11, K256);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_valid", key_valid, 1);
    check("err_nr", nr, 10);
    @(negedge clk);
    check("err_clear", err, 0);
    issue(5, r128[5]);

    kick(2'b01, K192);
    check("restart_valid", key_valid, 0);
    check("restart_busy", busy, 1);
    check("restart_nr", nr, 0);
    issue(0, 0);
    wait_done(lat);
    check("lat192", lat, 48);
    check("nr192", nr, 12);
    issue(12, 128'he98ba06f448c773c8ecc720401002202);
    issue(13, 0);

    kick(2'b10, K256);
    wait_done(lat);
    check("lat256", lat, 54);
    check("nr256", nr, 14);
    issue(14, 128'hfe4890d1e6188d0b046df344706c631e);
    issue(1, 128'h1f352c073b6108d72d9810a30914dff4);
    issue(0, 128'h603deb1015ca71be2b73aef0857d7781);

    kick(2'b00, K128);
    repeat (19) @(negedge clk);
    start = 1'b1;
    key_len = 2'b10;
    cipher_key = {8{32'h0badf00d}};
    @(negedge clk);
    start = 1'b0;
    check("busy_start_err", err, 0);
    check("busy_start_busy", busy, 1);
    wait_done(lat);
    check("lat_busy_start", lat, 42);
    check("nr_busy_start", nr, 10);
    issue(10, r128[10]);
    issue(1, r128[1]);
    issue(4, r128[4]);

    kick(2'b10, K256);
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_valid", key_valid, 0);
    check("mid_nr", nr, 0);
    check("mid_rk", rk_out, 0);
    check("mid_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(2'b00, K128);
    wait_done(lat);
    check("lat_after_rst", lat, 42);
    check("nr_after_rst", nr, 10);
    issue(10, r128[10]);
    issue(7, r128[7]);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
